// File: rtl/dump_window_ctrl.sv
// Frame-counted capture-window controller: one window per channel, opened and closed on vsync frame boundaries.
// Define DUMP_REPEAT_EN to add the per-channel `period` input, which turns closed windows back into waiting ones.
module dump_window_ctrl #(
    parameter int CH       = 2,
    parameter int FW       = 16,
    parameter int SYNC     = 2,
    parameter int ARM_MODE = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             vs,
    input  logic             dwnld,
    input  logic [CH*FW-1:0] start_frame,
    input  logic [CH*FW-1:0] win_len,
`ifdef DUMP_REPEAT_EN
    input  logic [CH*FW-1:0] period,
`endif
    output logic [FW-1:0]    frame_cnt,
    output logic             armed,
    output logic [CH-1:0]    dump_on,
    output logic [CH-1:0]    dump_start,
    output logic [CH-1:0]    dump_stop
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ON, S_DONE} ch_state_t;

    localparam logic [FW-1:0] FRAME_MAX = '1;

    logic [SYNC-1:0] vs_sync;
    logic [SYNC-1:0] dl_sync;
    logic            vs_prev;
    logic            dl_prev;
    logic            arm_done;
    logic            vs_fall;
    logic            dl_fall;
    logic            arm_evt;
    logic            frame_tick;
    logic [FW-1:0]   cnt_next;

    // Input synchronisers plus one extra stage for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_sync  <= '0;
            dl_sync  <= '0;
            vs_prev  <= 1'b0;
            dl_prev  <= 1'b0;
            arm_done <= 1'b0;
        end else begin
            vs_sync  <= {vs_sync[SYNC-2:0], vs};
            dl_sync  <= {dl_sync[SYNC-2:0], dwnld};
            vs_prev  <= vs_sync[SYNC-1];
            dl_prev  <= dl_sync[SYNC-1];
            arm_done <= 1'b1;
        end
    end

    assign vs_fall = vs_prev & ~vs_sync[SYNC-1];
    assign dl_fall = dl_prev & ~dl_sync[SYNC-1];
    assign arm_evt = (ARM_MODE == 0) ? ~arm_done : dl_fall;

    // An arm in the same cycle swallows the boundary; a saturated counter ignores boundaries entirely
    assign frame_tick = vs_fall & armed & ~arm_evt & (frame_cnt != FRAME_MAX);

    always_comb begin
        cnt_next = frame_cnt;
        if (arm_evt) begin
            cnt_next = '0;
        end else if (frame_tick) begin
            cnt_next = frame_cnt + FW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt <= '0;
            armed     <= 1'b0;
        end else begin
            frame_cnt <= cnt_next;
            armed     <= armed | arm_evt;
        end
    end

    for (genvar i = 0; i < CH; i++) begin : g_ch
        ch_state_t     state;
        ch_state_t     state_nxt;
        logic [FW-1:0] wcnt;
        logic [FW-1:0] wcnt_nxt;
        logic [FW-1:0] sf;
        logic [FW-1:0] wl;
        logic [FW-1:0] target;
        logic          on_q;
        logic          start_q;
        logic          stop_q;
        logic          start_nxt;
        logic          stop_nxt;

        assign sf = start_frame[i*FW +: FW];
        assign wl = win_len[i*FW +: FW];

`ifdef DUMP_REPEAT_EN
        logic [FW-1:0] ofs;
        logic [FW-1:0] ofs_nxt;
        logic [FW-1:0] per;

        assign per    = period[i*FW +: FW];
        assign target = sf + ofs;
`else
        assign target = sf;
`endif

        always_comb begin
            state_nxt = state;
            wcnt_nxt  = wcnt;
            start_nxt = 1'b0;
            stop_nxt  = 1'b0;
`ifdef DUMP_REPEAT_EN
            ofs_nxt   = ofs;
`endif
            if (arm_evt) begin
                stop_nxt = (state == S_ON);
`ifdef DUMP_REPEAT_EN
                ofs_nxt  = '0;
`endif
                if (sf == '0) begin
                    state_nxt = S_ON;
                    wcnt_nxt  = '0;
                    start_nxt = 1'b1;
                end else begin
                    state_nxt = S_WAIT;
                end
            end else if (frame_tick) begin
                case (state)
                    S_WAIT: begin
                        if (cnt_next == target) begin
                            state_nxt = S_ON;
                            wcnt_nxt  = '0;
                            start_nxt = 1'b1;
                        end
                    end
                    S_ON: begin
                        wcnt_nxt = wcnt + FW'(1);
                        if (wl != '0 && wcnt_nxt == wl) begin
                            stop_nxt  = 1'b1;
                            state_nxt = S_DONE;
`ifdef DUMP_REPEAT_EN
                            // Re-aim one period past the previous target, wrapping at the field width
                            if (per != '0) begin
                                state_nxt = S_WAIT;
                                ofs_nxt   = ofs + per;
                            end
`endif
                        end
                    end
                    default: ;
                endcase
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state   <= S_IDLE;
                wcnt    <= '0;
                on_q    <= 1'b0;
                start_q <= 1'b0;
                stop_q  <= 1'b0;
`ifdef DUMP_REPEAT_EN
                ofs     <= '0;
`endif
            end else begin
                state   <= state_nxt;
                wcnt    <= wcnt_nxt;
                on_q    <= (state_nxt == S_ON);
                start_q <= start_nxt;
                stop_q  <= stop_nxt;
`ifdef DUMP_REPEAT_EN
                ofs     <= ofs_nxt;
`endif
            end
        end

        assign dump_on[i]    = on_q;
        assign dump_start[i] = start_q;
        assign dump_stop[i]  = stop_q;
    end

endmodule

// File: tb/tb_dump_window_ctrl.sv
// Scoreboard bench for dump_window_ctrl: one instance armed at reset release (FW=4), one armed by dwnld (FW=3).
// A frame-level reference model predicts every cycle's outputs; a monitor compares them after each clock edge.
module tb_dump_window_ctrl;

    localparam int CH   = 2;
    localparam int SYNC = 2;
    localparam int FWA  = 4;
    localparam int FWB  = 3;

    typedef struct packed {
        logic [31:0]   f;
        logic          armed;
        logic [CH-1:0] on_v;
        logic [CH-1:0] st_v;
        logic [CH-1:0] sp_v;
    } dexp_t;

    typedef struct packed {
        logic [31:0] edge_n;
        dexp_t       a;
        dexp_t       b;
    } exp_t;

    logic              clk;
    logic              rst_n;
    logic              vs;
    logic              dwnld;
    logic [CH*FWA-1:0] sf_a;
    logic [CH*FWA-1:0] wl_a;
    logic [CH*FWB-1:0] sf_b;
    logic [CH*FWB-1:0] wl_b;
`ifdef DUMP_REPEAT_EN
    logic [CH*FWA-1:0] per_a;
    logic [CH*FWB-1:0] per_b;
`endif
    logic [FWA-1:0]    fc_a;
    logic [FWB-1:0]    fc_b;
    logic              armed_a;
    logic              armed_b;
    logic [CH-1:0]     on_a, st_a, sp_a;
    logic [CH-1:0]     on_b, st_b, sp_b;

    int   edge_no;
    int   n_total;
    int   n_bad;
    exp_t sb[$];
    int   vs_due[$];
    int   dl_due[$];
    bit   arm_pend;

    int cfg_sf[2][CH];
    int cfg_wl[2][CH];
    int cfg_per[2][CH];
    int m_f[2];
    bit m_armed[2];
    bit m_on[2][CH];
    bit m_wait[2][CH];
    int m_open[2][CH];
    int m_ofs[2][CH];

    dump_window_ctrl #(.CH(CH), .FW(FWA), .SYNC(SYNC), .ARM_MODE(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .vs(vs), .dwnld(dwnld),
        .start_frame(sf_a), .win_len(wl_a),
`ifdef DUMP_REPEAT_EN
        .period(per_a),
`endif
        .frame_cnt(fc_a), .armed(armed_a),
        .dump_on(on_a), .dump_start(st_a), .dump_stop(sp_a)
    );

    dump_window_ctrl #(.CH(CH), .FW(FWB), .SYNC(SYNC), .ARM_MODE(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .vs(vs), .dwnld(dwnld),
        .start_frame(sf_b), .win_len(wl_b),
`ifdef DUMP_REPEAT_EN
        .period(per_b),
`endif
        .frame_cnt(fc_b), .armed(armed_b),
        .dump_on(on_b), .dump_start(st_b), .dump_stop(sp_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) edge_no <= edge_no + 1;

    task automatic cmp(input string name, input int got, input int want, input int en);
        n_total++;
        if (got != want) begin
            n_bad++;
            $display("[TB] FAIL %s @edge %0d: got %0d, want %0d", name, en, got, want);
        end
    endtask

    task automatic checkOutput(input exp_t e);
        int en;
        en = int'(e.edge_n);
        cmp("a.frame_cnt",  int'(fc_a),    int'(e.a.f),     en);
        cmp("a.armed",      int'(armed_a), int'(e.a.armed), en);
        cmp("a.dump_on",    int'(on_a),    int'(e.a.on_v),  en);
        cmp("a.dump_start", int'(st_a),    int'(e.a.st_v),  en);
        cmp("a.dump_stop",  int'(sp_a),    int'(e.a.sp_v),  en);
        cmp("b.frame_cnt",  int'(fc_b),    int'(e.b.f),     en);
        cmp("b.armed",      int'(armed_b), int'(e.b.armed), en);
        cmp("b.dump_on",    int'(on_b),    int'(e.b.on_v),  en);
        cmp("b.dump_start", int'(st_b),    int'(e.b.st_v),  en);
        cmp("b.dump_stop",  int'(sp_b),    int'(e.b.sp_v),  en);
    endtask

    // Monitor: after every edge, compare against the prediction queued for that edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            while (sb.size() > 0 && int'(sb[0].edge_n) < edge_no) begin
                e = sb.pop_front();
                cmp("sb_order", edge_no, int'(e.edge_n), int'(e.edge_n));
            end
            if (sb.size() > 0 && int'(sb[0].edge_n) == edge_no) begin
                e = sb.pop_front();
                checkOutput(e);
            end
        end
    end

    task automatic model_clear();
        for (int d = 0; d < 2; d++) begin
            m_f[d]     = 0;
            m_armed[d] = 1'b0;
            for (int c = 0; c < CH; c++) begin
                m_on[d][c]   = 1'b0;
                m_wait[d][c] = 1'b0;
                m_open[d][c] = 0;
                m_ofs[d][c]  = 0;
            end
        end
    endtask

    // Frame-level model: a window is open from frame start(+offset) until it has lasted win_len frames
    task automatic model_step(input int d, input bit arm, input bit vsf, output dexp_t e);
        int fmax;
        fmax = (d == 0) ? (1 << FWA) - 1 : (1 << FWB) - 1;
        e = '0;
        if (arm) begin
            m_f[d]     = 0;
            m_armed[d] = 1'b1;
            for (int c = 0; c < CH; c++) begin
                if (m_on[d][c]) e.sp_v[c] = 1'b1;
                m_on[d][c]   = 1'b0;
                m_wait[d][c] = 1'b1;
                m_ofs[d][c]  = 0;
                if (cfg_sf[d][c] == 0) begin
                    m_on[d][c]   = 1'b1;
                    m_wait[d][c] = 1'b0;
                    m_open[d][c] = 0;
                    e.st_v[c]    = 1'b1;
                end
            end
        end else if (vsf && m_armed[d] && m_f[d] < fmax) begin
            m_f[d]++;
            for (int c = 0; c < CH; c++) begin
                if (m_on[d][c]) begin
                    if (cfg_wl[d][c] != 0 && m_f[d] - m_open[d][c] == cfg_wl[d][c]) begin
                        m_on[d][c] = 1'b0;
                        e.sp_v[c]  = 1'b1;
`ifdef DUMP_REPEAT_EN
                        if (cfg_per[d][c] != 0) begin
                            m_wait[d][c] = 1'b1;
                            m_ofs[d][c]  = (m_ofs[d][c] + cfg_per[d][c]) & fmax;
                        end
`endif
                    end
                end else if (m_wait[d][c] && m_f[d] == ((cfg_sf[d][c] + m_ofs[d][c]) & fmax)) begin
                    m_on[d][c]   = 1'b1;
                    m_wait[d][c] = 1'b0;
                    m_open[d][c] = m_f[d];
                    e.st_v[c]    = 1'b1;
                end
            end
        end
        e.f     = 32'(m_f[d]);
        e.armed = m_armed[d];
        for (int c = 0; c < CH; c++) e.on_v[c] = m_on[d][c];
    endtask

    // Drive one cycle of inputs at the falling edge and queue the prediction for the next rising edge
    task automatic applyStimulus(input bit r, input bit v, input bit dl);
        int    n;
        bit    vsf;
        bit    dlf;
        bit    arm_a;
        dexp_t ea;
        dexp_t eb;
        exp_t  e;
        @(negedge clk);
        n = edge_no + 1;
        if (r && rst_n) begin
            if (vs && !v)    vs_due.push_back(n + SYNC);
            if (dwnld && !dl) dl_due.push_back(n + SYNC);
        end
        rst_n = r;
        vs    = v;
        dwnld = dl;
        for (int c = 0; c < CH; c++) begin
            sf_a[c*FWA +: FWA] = FWA'(cfg_sf[0][c]);
            wl_a[c*FWA +: FWA] = FWA'(cfg_wl[0][c]);
            sf_b[c*FWB +: FWB] = FWB'(cfg_sf[1][c]);
            wl_b[c*FWB +: FWB] = FWB'(cfg_wl[1][c]);
`ifdef DUMP_REPEAT_EN
            per_a[c*FWA +: FWA] = FWA'(cfg_per[0][c]);
            per_b[c*FWB +: FWB] = FWB'(cfg_per[1][c]);
`endif
        end
        e = '0;
        e.edge_n = 32'(n);
        if (!r) begin
            model_clear();
            vs_due.delete();
            dl_due.delete();
            arm_pend = 1'b1;
            sb.push_back(e);
            return;
        end
        arm_a    = arm_pend;
        arm_pend = 1'b0;
        vsf = 1'b0;
        dlf = 1'b0;
        if (vs_due.size() > 0 && vs_due[0] == n) begin
            vsf = 1'b1;
            void'(vs_due.pop_front());
        end
        if (dl_due.size() > 0 && dl_due[0] == n) begin
            dlf = 1'b1;
            void'(dl_due.pop_front());
        end
        model_step(0, arm_a, vsf, ea);
        model_step(1, dlf, vsf, eb);
        e.a = ea;
        e.b = eb;
        sb.push_back(e);
    endtask

    task automatic hold(input int cycles);
        for (int k = 0; k < cycles; k++) applyStimulus(1'b1, vs, dwnld);
    endtask

    task automatic vs_pulse(input int count);
        int h;
        for (int k = 0; k < count; k++) begin
            h = SYNC + 1 + $urandom_range(0, 2);
            applyStimulus(1'b1, 1'b0, dwnld);
            hold(h - 1);
            applyStimulus(1'b1, 1'b1, dwnld);
            hold(h - 1);
        end
    endtask

    task automatic do_reset(input int cycles);
        for (int k = 0; k < cycles; k++) applyStimulus(1'b0, vs, dwnld);
        applyStimulus(1'b1, vs, dwnld);
        hold(SYNC + 2);
    endtask

    task automatic rearm_b();
        if (!dwnld) begin
            applyStimulus(1'b1, vs, 1'b1);
            hold(SYNC + 1);
        end
        applyStimulus(1'b1, vs, 1'b0);
        hold(SYNC + 1);
    endtask

    task automatic set_cfg(input int d, input int c, input int sf, input int wl, input int per);
        cfg_sf[d][c]  = sf;
        cfg_wl[d][c]  = wl;
        cfg_per[d][c] = per;
    endtask

    initial begin
        n_total  = 0;
        n_bad    = 0;
        arm_pend = 1'b1;
        rst_n    = 1'b1;
        vs       = 1'b1;
        dwnld    = 1'b1;
        model_clear();
        set_cfg(0, 0, 3, 2, 0);
        set_cfg(0, 1, 0, 0, 0);
        set_cfg(1, 0, 7, 0, 0);
        set_cfg(1, 1, 2, 3, 0);
        #1 rst_n = 1'b0;

        // Reset values, then arm on release (a) and on the first dwnld fall (b)
        do_reset(3);
        rearm_b();

        // a: window on frames 3-4; b: saturates at 7 and opens ch0 once
        vs_pulse(9);

        // b: re-arm while ch1 is open at frame 4
        rearm_b();
        vs_pulse(4);
        rearm_b();

        // b: arm and a synchronised vsync fall land on the same edge
        applyStimulus(1'b1, vs, 1'b1);
        hold(SYNC + 1);
        applyStimulus(1'b1, 1'b0, 1'b0);
        hold(SYNC + 1);
        applyStimulus(1'b1, 1'b1, 1'b0);
        hold(SYNC + 1);

        // Reset with a frame boundary still in the synchroniser
        vs_pulse(2);
        applyStimulus(1'b1, 1'b0, dwnld);
        do_reset(2);
        rearm_b();
        vs_pulse(3);

`ifdef DUMP_REPEAT_EN
        set_cfg(0, 0, 2, 1, 4);
        do_reset(2);
        vs_pulse(15);
`endif

        for (int it = 0; it < 40; it++) begin
            for (int c = 0; c < CH; c++) begin
                set_cfg(0, c, $urandom_range(0, 6), $urandom_range(0, 3), $urandom_range(0, 5));
                set_cfg(1, c, $urandom_range(0, 7), $urandom_range(0, 3), $urandom_range(0, 5));
            end
            case ($urandom_range(0, 9))
                0: do_reset($urandom_range(1, 3));
                1, 2, 3: rearm_b();
                4: begin
                    applyStimulus(1'b1, 1'b1, 1'b1);
                    hold(SYNC + 1);
                    applyStimulus(1'b1, 1'b0, 1'b0);
                    hold(SYNC + 1);
                    applyStimulus(1'b1, 1'b1, 1'b0);
                    hold(SYNC + 1);
                end
                default: ;
            endcase
            vs_pulse($urandom_range(1, 6));
        end

        hold(SYNC + 4);
        @(posedge clk);
        #2;
        cmp("sb_drain", sb.size(), 0, edge_no);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
